// File: rtl/fetch_decode_queue.sv
// Circular FIFO between fetch and decode carrying {instr, npc, taken} entries.
// A decode flush squashes all entries and returns a registered one-cycle redirect to fetch.
module fetch_decode_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_instr,
  input  logic [WIDTH-1:0]           enq_npc,
  input  logic                       enq_taken,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_instr,
  output logic [WIDTH-1:0]           deq_npc,
  output logic                       deq_taken,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           flush_target,
  output logic                       redirect_valid,
  output logic [WIDTH-1:0]           branch_target,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] npc;
    logic             taken;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             head_entry;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               redirect_q, redirect_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic               enq_fire, deq_fire;

  // Redirect cycle also blocks enqueue so wrong-path fetches in flight are dropped.
  assign enq_ready = (count_q != CNT_W'(DEPTH)) & ~flush & ~redirect_q;
  assign deq_valid = (count_q != '0) & ~flush;
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  assign head_entry     = mem_q[head_q];
  assign deq_instr      = head_entry.instr;
  assign deq_npc        = head_entry.npc;
  assign deq_taken      = head_entry.taken;
  assign redirect_valid = redirect_q;
  assign branch_target  = target_q;
  assign count          = count_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    redirect_d = 1'b0;
    target_d   = target_q;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      redirect_d = 1'b1;
      target_d   = flush_target;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (deq_fire) head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge CLK) begin
    if (enq_fire) begin
      mem_q[tail_q] <= '{instr: enq_instr, npc: enq_npc, taken: enq_taken};
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue: handshakes, full/empty, streaming wrap, flush and reset.
module tb_fetch_decode_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        enq_valid, enq_ready, enq_taken;
  logic [31:0] enq_instr, enq_npc;
  logic        deq_valid, deq_ready, deq_taken;
  logic [31:0] deq_instr, deq_npc;
  logic        flush;
  logic [31:0] flush_target;
  logic        redirect_valid;
  logic [31:0] branch_target;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_decode_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_instr(enq_instr),
    .enq_npc(enq_npc), .enq_taken(enq_taken),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_instr(deq_instr),
    .deq_npc(deq_npc), .deq_taken(deq_taken),
    .flush(flush), .flush_target(flush_target),
    .redirect_valid(redirect_valid), .branch_target(branch_target),
    .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] ins, input logic [31:0] npc, input logic tk);
    enq_valid = v;
    enq_instr = ins;
    enq_npc   = npc;
    enq_taken = tk;
  endtask

  initial begin
    nRST = 1'b0;
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    deq_ready = 1'b0;
    flush = 1'b0;
    flush_target = 32'h0;
    cyc();
    cyc();
    nRST = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_redirect", 32'(redirect_valid), 32'd0);
    check("rst_target", branch_target, 32'h0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);

    // Single entry: no fall-through, visible one cycle later.
    set_enq(1'b1, 32'h8C220004, 32'h4, 1'b0);
    #1;
    check("a_deq_valid_enq_cycle", 32'(deq_valid), 32'd0);
    cyc();
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("a_deq_valid", 32'(deq_valid), 32'd1);
    check("a_instr", deq_instr, 32'h8C220004);
    check("a_npc", deq_npc, 32'h4);
    check("a_taken", 32'(deq_taken), 32'd0);
    check("a_count", 32'(count), 32'd1);
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    #1;
    check("a_drained", 32'(count), 32'd0);

    // Fill to full with decode stalled; 5th entry must be held.
    for (int i = 0; i < 4; i++) begin
      set_enq(1'b1, 32'h10 + 32'(i), 32'h100 + 32'(4*i), i[0]);
      #1;
      check("fill_ready", 32'(enq_ready), 32'd1);
      cyc();
    end
    set_enq(1'b1, 32'h14, 32'h110, 1'b0);
    #1;
    check("full_count", 32'(count), 32'd4);
    check("full_enq_ready", 32'(enq_ready), 32'd0);
    cyc();
    check("full_held_count", 32'(count), 32'd4);
    deq_ready = 1'b1;
    #1;
    check("full_no_bypass", 32'(enq_ready), 32'd0);
    check("drain0_instr", deq_instr, 32'h10);
    check("drain0_npc", deq_npc, 32'h100);
    check("drain0_taken", 32'(deq_taken), 32'd0);
    cyc();
    check("drain1_count", 32'(count), 32'd3);
    check("drain1_enq_ready", 32'(enq_ready), 32'd1);
    check("drain1_instr", deq_instr, 32'h11);
    check("drain1_taken", 32'(deq_taken), 32'd1);
    cyc();
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("drain_both_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("drain_order", deq_instr, 32'h12 + 32'(i));
      cyc();
    end
    check("drain_empty_count", 32'(count), 32'd0);
    check("drain_empty_valid", 32'(deq_valid), 32'd0);
    deq_ready = 1'b0;

    // Streaming 0..9 with both sides always ready.
    deq_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_enq(1'b1, 32'(k), 32'(4*k + 4), 1'b0);
      #1;
      if (k == 0) begin
        check("stream_fill_valid", 32'(deq_valid), 32'd0);
      end else begin
        check("stream_instr", deq_instr, 32'(k - 1));
        check("stream_count", 32'(count), 32'd1);
      end
      cyc();
    end
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("stream_last", deq_instr, 32'd9);
    cyc();
    check("stream_end_count", 32'(count), 32'd0);
    deq_ready = 1'b0;

    // Flush with 3 queued and a same-cycle enqueue attempt.
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'hA0 + 32'(i), 32'h0, 1'b0);
      cyc();
    end
    check("pre_flush_count", 32'(count), 32'd3);
    set_enq(1'b1, 32'hBB, 32'h0, 1'b0);
    flush = 1'b1;
    flush_target = 32'h100;
    #1;
    check("flush_deq_valid", 32'(deq_valid), 32'd0);
    check("flush_enq_ready", 32'(enq_ready), 32'd0);
    cyc();
    flush = 1'b0;
    #1;
    check("redir_count", 32'(count), 32'd0);
    check("redir_valid", 32'(redirect_valid), 32'd1);
    check("redir_target", branch_target, 32'h100);
    check("redir_enq_ready", 32'(enq_ready), 32'd0);
    cyc();
    check("post_redir_valid", 32'(redirect_valid), 32'd0);
    check("post_redir_enq_ready", 32'(enq_ready), 32'd1);
    check("post_redir_count", 32'(count), 32'd0);
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);

    // Back-to-back flushes extend the redirect and update the target.
    flush = 1'b1;
    flush_target = 32'h100;
    cyc();
    flush_target = 32'h200;
    #1;
    check("b2b_valid1", 32'(redirect_valid), 32'd1);
    check("b2b_target1", branch_target, 32'h100);
    cyc();
    flush = 1'b0;
    #1;
    check("b2b_valid2", 32'(redirect_valid), 32'd1);
    check("b2b_target2", branch_target, 32'h200);
    cyc();
    check("b2b_end", 32'(redirect_valid), 32'd0);

    // Reset with two entries queued and a flush requested at the same edge.
    for (int i = 0; i < 2; i++) begin
      set_enq(1'b1, 32'hC0 + 32'(i), 32'h0, 1'b0);
      cyc();
    end
    set_enq(1'b0, 32'h0, 32'h0, 1'b0);
    check("pre_rst_count", 32'(count), 32'd2);
    flush = 1'b1;
    flush_target = 32'h300;
    nRST = 1'b0;
    cyc();
    flush = 1'b0;
    nRST = 1'b1;
    #1;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_deq_valid", 32'(deq_valid), 32'd0);
    check("mrst_redirect", 32'(redirect_valid), 32'd0);
    check("mrst_target", branch_target, 32'h0);

    // Reset while a redirect is being signalled discards it.
    flush = 1'b1;
    flush_target = 32'h400;
    cyc();
    flush = 1'b0;
    #1;
    check("pend_redirect", 32'(redirect_valid), 32'd1);
    nRST = 1'b0;
    cyc();
    nRST = 1'b1;
    #1;
    check("pend_rst_redirect", 32'(redirect_valid), 32'd0);
    check("pend_rst_target", branch_target, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Parametrised, buffered successor to the fetch/decode latch.
- Circular FIFO holding {instruction, instr_npc, branch_taken} entries between fetch and decode, with valid/ready handshakes on both sides.
- Decode-initiated flush squashes all entries and returns a registered, one-cycle branch redirect (target PC) to fetch.
- Lets fetch run ahead of a stalled decode by up to DEPTH instructions.

Parameters:
- WIDTH, 32, bit width of instruction and PC fields (word_t width).
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- CLK  input  1  system clock, all state on rising edge
- nRST  input  1  synchronous active-low reset
- enq_valid  input  1  fetch presents an entry
- enq_ready  output  1  queue accepts an entry this cycle
- enq_instr  input  WIDTH  fetched instruction
- enq_npc  input  WIDTH  PC+4 of fetched instruction
- enq_taken  input  1  fetch predicted taken
- deq_valid  output  1  head entry valid for decode
- deq_ready  input  1  decode consumes head this cycle
- deq_instr  output  WIDTH  head instruction
- deq_npc  output  WIDTH  head instr_npc
- deq_taken  output  1  head branch_taken
- flush  input  1  decode detected mispredict; squash queue
- flush_target  input  WIDTH  correct PC accompanying flush
- redirect_valid  output  1  one-cycle pulse to fetch: redirect now
- branch_target  output  WIDTH  redirect PC, valid while redirect_valid
- count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: DEPTH-entry register array; head and tail pointers of $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count tracks occupancy 0..DEPTH.
- Reset (nRST low at rising edge): head=tail=count=0, redirect_valid=0, branch_target=0, squash state cleared. Array contents need not be reset. Reset mid-operation discards all entries and any pending redirect.
- Transfers:
  - enq fires when enq_valid & enq_ready.
  - deq fires when deq_valid & deq_ready.
- Outputs:
  - deq_valid = (count != 0) & !flush.
  - deq_instr/npc/taken always show the head entry. Contents are don't-care when deq_valid=0.
  - enq_ready = (count != DEPTH) & !flush & !redirect_valid.
- Full: enq_ready=0 even if deq fires the same cycle (no full-bypass).
- Empty: no fall-through. An entry enqueued at edge N is visible on deq_* after that edge, i.e. minimum latency 1 cycle.
- Enq and deq in the same cycle (0 < count < DEPTH): both pointers advance, count unchanged.
- Enq only: tail+1, count+1. Deq only: head+1, count-1.
- Flush (priority over everything else, including simultaneous enq/deq, which are suppressed by the gating above):
  - Next edge: head=tail=count=0.
  - Next edge: redirect_valid<=1 and branch_target<=flush_target.
- Redirect:
  - redirect_valid is high for exactly one cycle, unless flush is re-asserted that cycle; in that case it stays high and branch_target updates to the new flush_target.
  - enq_ready is held 0 during the flush cycle and the redirect cycle, so wrong-path fetches are dropped.
- Enqueue resumes the cycle after redirect_valid falls.
- Flush while empty: legal; still produces the redirect pulse.
- Pointer wrap: tail at DEPTH-1 advances to 0; FIFO order is preserved across the wrap.

Test Plan:
- Reset, then enq A (instr 0x8C220004, npc 0x4, taken 0). Require:
  - deq_valid=0 in the enq cycle.
  - Next cycle deq_valid=1, deq_instr=0x8C220004, deq_npc=0x4, count=1.
- Hold deq_ready=0 and enq 5 entries with DEPTH=4:
  - The first 4 are accepted, count=4, enq_ready=0, the 5th is held.
  - With deq_ready=1 the entries drain in order, and the 5th is accepted once count=3.
- Steady streaming with enq_valid=deq_ready=1 for 10 cycles, values 0..9:
  - After the 1-cycle fill, count stays 1.
  - Output sequence is 0..9 in order, with the tail wrapping at least twice.
- Flush with 3 entries queued, flush_target=0x00000100, enq_valid=1 the same cycle:
  - deq_valid=0 in the flush cycle.
  - Next cycle count=0, redirect_valid=1, branch_target=0x100, enq_ready=0.
  - The following cycle redirect_valid=0 and enq_ready=1.
- Back-to-back flush with targets 0x100 then 0x200: redirect_valid stays high 2 cycles, with branch_target 0x100 then 0x200.
- Assert nRST=0 for one edge with count=2 and a redirect pending: count=0, deq_valid=0, redirect_valid=0, branch_target=0 after that edge.
